// File: rtl/alu_result_fifo_pkg.sv
// Shared execute-stage result types used by the ALU result buffer and the CDB arbiter.
// alu_result_t field order is fixed; downstream packers rely on data being the MSBs.
package alu_result_fifo_pkg;

  localparam int WORD_W   = 32;
  localparam int ROB_ID_W = 5;

  typedef logic [WORD_W-1:0]   word_t;
  typedef logic [ROB_ID_W-1:0] rob_id_t;

  typedef struct packed {
    word_t   data;
    rob_id_t rob_id;
    logic    jump;
    word_t   target;
  } alu_result_t;

  localparam int ALU_RESULT_W = $bits(alu_result_t);

endpackage

// File: rtl/alu_result_fifo_mem.sv
// DEPTH x WIDTH register array: synchronous write, asynchronous read, contents never reset.
// Shared by the execute-stage queues; all pointer and handshake control lives in the owner.
module alu_result_fifo_mem #(
  parameter  int DEPTH  = 4,
  parameter  int WIDTH  = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/alu_result_fifo.sv
// Ordered ALU result buffer between execute and CDB arbiter; 1-cycle in->cdb latency, no bypass.
// in_ready_o drops only when full (pre-pop), so CDB back-pressure never reaches execute otherwise.
module alu_result_fifo
  import alu_result_fifo_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  input  logic           in_valid_i,
  output logic           in_ready_o,
  input  word_t          in_data_i,
  input  rob_id_t        in_rob_id_i,
  input  logic           in_jump_i,
  input  word_t          in_target_i,
  output logic           cdb_valid_o,
  input  logic           cdb_ready_i,
  output word_t          cdb_data_o,
  output rob_id_t        cdb_rob_id_o,
  output logic           cdb_jump_o,
  output word_t          cdb_target_o,
  output logic [PTR_W:0] count_o
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [PTR_W-1:0] r_wr;
  logic [PTR_W-1:0] r_rd;
  logic [PTR_W:0]   r_cnt;

  logic        w_push;
  logic        w_pop;
  logic        w_clear;
  alu_result_t w_wdata;
  alu_result_t w_rdata;

  assign in_ready_o  = (r_cnt != FULL_CNT);
  assign cdb_valid_o = (r_cnt != '0);
  assign count_o     = r_cnt;

  assign w_clear = rst | flush;
  assign w_push  = in_valid_i & in_ready_o;
  assign w_pop   = cdb_valid_o & cdb_ready_i;

  assign w_wdata = '{data: in_data_i, rob_id: in_rob_id_i, jump: in_jump_i, target: in_target_i};

  // Writes are suppressed on clear so a flushed result never lands in the array.
  alu_result_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ALU_RESULT_W)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push & ~w_clear),
    .i_waddr (r_wr),
    .i_wdata (w_wdata),
    .i_raddr (r_rd),
    .o_rdata (w_rdata)
  );

  assign cdb_data_o   = w_rdata.data;
  assign cdb_rob_id_o = w_rdata.rob_id;
  assign cdb_jump_o   = w_rdata.jump;
  assign cdb_target_o = w_rdata.target;

  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wr <= r_wr + 1'b1;
      end
      if (w_pop) begin
        r_rd <= r_rd + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed + random bench for alu_result_fifo with a queue scoreboard checked every cycle.
module tb_alu_result_fifo;
  import alu_result_fifo_pkg::*;

  localparam int DEPTH = 4;

  logic    clk = 1'b0;
  logic    rst, flush, in_valid_i, in_ready_o, in_jump_i;
  word_t   in_data_i, in_target_i;
  rob_id_t in_rob_id_i;
  logic    cdb_valid_o, cdb_ready_i, cdb_jump_o;
  word_t   cdb_data_o, cdb_target_o;
  rob_id_t cdb_rob_id_o;
  logic [2:0] count_o;

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;
  alu_result_t q[$];

  alu_result_fifo #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .in_data_i    (in_data_i),
    .in_rob_id_i  (in_rob_id_i),
    .in_jump_i    (in_jump_i),
    .in_target_i  (in_target_i),
    .cdb_valid_o  (cdb_valid_o),
    .cdb_ready_i  (cdb_ready_i),
    .cdb_data_o   (cdb_data_o),
    .cdb_rob_id_o (cdb_rob_id_o),
    .cdb_jump_o   (cdb_jump_o),
    .cdb_target_o (cdb_target_o),
    .count_o      (count_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare registered outputs mid-cycle, then advance the model with the
  // inputs that the coming rising edge will sample.
  always @(negedge clk) begin
    if (mon_en) begin
      check("in_ready", 72'(in_ready_o), 72'(q.size() != DEPTH));
      check("cdb_valid", 72'(cdb_valid_o), 72'(q.size() != 0));
      check("count", 72'(count_o), 72'(q.size()));
      if (q.size() != 0)
        check("payload", 72'({cdb_data_o, cdb_rob_id_o, cdb_jump_o, cdb_target_o}), 72'(q[0]));
    end
    if (rst || flush) begin
      q.delete();
    end else begin
      automatic bit full = (q.size() == DEPTH);
      if (q.size() != 0 && cdb_ready_i) void'(q.pop_front());
      if (in_valid_i && !full)
        q.push_back('{data: in_data_i, rob_id: in_rob_id_i, jump: in_jump_i, target: in_target_i});
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input word_t d, input rob_id_t id, input logic j, input word_t t);
    in_valid_i  = v;
    in_data_i   = d;
    in_rob_id_i = id;
    in_jump_i   = j;
    in_target_i = t;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; cdb_ready_i = 1'b0;
    drive(1'b0, '0, '0, 1'b0, '0);

    // Reset, then an idle grant on an empty buffer.
    cyc(2);
    mon_en = 1'b1;
    check("rst_ready", 72'(in_ready_o), 72'(1));
    check("rst_valid", 72'(cdb_valid_o), 72'(0));
    check("rst_count", 72'(count_o), 72'(0));
    rst = 1'b0; cdb_ready_i = 1'b1;
    cyc(2);
    check("empty_grant_count", 72'(count_o), 72'(0));

    // Fill to full with no grant; fifth push must bounce.
    cdb_ready_i = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, word_t'(32'h11 * i), rob_id_t'(i), 1'b0, '0);
      cyc(1);
    end
    drive(1'b1, 32'h55, 5'd5, 1'b0, '0);
    cyc(1);
    check("full_count", 72'(count_o), 72'(4));
    check("full_ready", 72'(in_ready_o), 72'(0));
    drive(1'b0, '0, '0, 1'b0, '0);
    cdb_ready_i = 1'b1;
    check("drain_head", 72'(cdb_data_o), 72'(32'h11));
    cyc(4);
    check("drained_valid", 72'(cdb_valid_o), 72'(0));

    // Steady state at occupancy 2 with push and pop every cycle; pointers wrap.
    cdb_ready_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, word_t'(32'h100 + i), rob_id_t'(i), 1'b0, '0);
      cyc(1);
    end
    cdb_ready_i = 1'b1;
    for (int i = 2; i < 12; i++) begin
      drive(1'b1, word_t'(32'h100 + i), rob_id_t'(i), 1'b0, '0);
      cyc(1);
      check("steady_count", 72'(count_o), 72'(2));
    end
    drive(1'b0, '0, '0, 1'b0, '0);
    cyc(3);

    // Full with a same-cycle pop: pop wins, push retried next cycle.
    cdb_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, word_t'(32'h200 + i), rob_id_t'(i), 1'b0, '0);
      cyc(1);
    end
    drive(1'b1, 32'h2FF, 5'd9, 1'b0, '0);
    cdb_ready_i = 1'b1;
    cyc(1);
    check("full_pop_count", 72'(count_o), 72'(3));
    cdb_ready_i = 1'b0;
    cyc(1);
    check("retry_push_count", 72'(count_o), 72'(4));
    drive(1'b0, '0, '0, 1'b0, '0);
    cdb_ready_i = 1'b1;
    cyc(5);

    // Flush with push and pop both requested in the same cycle.
    cdb_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, word_t'(32'h300 + i), rob_id_t'(i), 1'b0, '0);
      cyc(1);
    end
    flush = 1'b1; cdb_ready_i = 1'b1;
    drive(1'b1, 32'h3FF, 5'd3, 1'b0, '0);
    cyc(1);
    flush = 1'b0; cdb_ready_i = 1'b0;
    check("flush_count", 72'(count_o), 72'(0));
    check("flush_valid", 72'(cdb_valid_o), 72'(0));
    check("flush_ready", 72'(in_ready_o), 72'(1));
    drive(1'b1, 32'hAA, 5'd10, 1'b0, '0);
    cyc(1);
    drive(1'b0, '0, '0, 1'b0, '0);
    cyc(2);
    check("post_flush_count", 72'(count_o), 72'(1));
    check("post_flush_data", 72'(cdb_data_o), 72'(32'hAA));
    cdb_ready_i = 1'b1;
    cyc(1);
    check("post_flush_empty", 72'(cdb_valid_o), 72'(0));

    // Jump payload held stable under back-pressure.
    cdb_ready_i = 1'b0;
    drive(1'b1, 32'hDEAD_0001, 5'd7, 1'b1, 32'h1C00_0100);
    cyc(1);
    drive(1'b0, '0, '0, 1'b0, '0);
    for (int i = 0; i < 5; i++) begin
      check("jump_flag", 72'(cdb_jump_o), 72'(1));
      check("jump_target", 72'(cdb_target_o), 72'(32'h1C00_0100));
      check("jump_rob", 72'(cdb_rob_id_o), 72'(7));
      cyc(1);
    end
    cdb_ready_i = 1'b1;
    cyc(1);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 2) != 0), word_t'($urandom), rob_id_t'($urandom),
            1'($urandom), word_t'($urandom));
      cdb_ready_i = 1'($urandom_range(0, 2) == 0 ? 0 : 1) & 1'(i % 40 < 30);
      flush = ($urandom_range(0, 31) == 0);
      cyc(1);
    end
    flush = 1'b0; cdb_ready_i = 1'b1;
    drive(1'b0, '0, '0, 1'b0, '0);
    cyc(6);
    check("final_empty", 72'(count_o), 72'(0));

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_result_fifo.md
# alu_result_fifo

Ordered result buffer between an ALU issue queue's execute stage and the CDB arbiter. Accepts one executed result per cycle over a valid/ready handshake, stores up to DEPTH results in issue order, and presents the oldest to the CDB arbiter until granted. Absorbs CDB back-pressure so the execute stage stalls only when the buffer is full. Flush discards all contents in one cycle.

## Interface
Parameters:
- DEPTH, 4: number of result entries; power of two, ≥2.
- PTR_W, $clog2(DEPTH): read/write pointer width (derived, not overridden).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  pipeline flush; synchronous; same effect on state as rst.
- in_valid_i  in  1  execute stage has a result this cycle.
- in_ready_o  out  1  buffer can accept (not full); this is the IQ's fifo_ready.
- in_data_i  in  word_t  ALU/jump result value.
- in_rob_id_i  in  rob_id_t  destination ROB id.
- in_jump_i  in  1  branch taken.
- in_target_i  in  word_t  branch target when in_jump_i.
- cdb_valid_o  out  1  oldest entry is presented.
- cdb_ready_i  in  1  CDB arbiter grant; entry retires when valid&ready.
- cdb_data_o  out  word_t  oldest entry data.
- cdb_rob_id_o  out  rob_id_t  oldest entry ROB id.
- cdb_jump_o  out  1  oldest entry jump flag.
- cdb_target_o  out  word_t  oldest entry jump target.
- count_o  out  PTR_W+1  current occupancy (debug/perf).

## Operation
- Storage: DEPTH-entry circular array of alu_result_t, write pointer wr_q, read pointer rd_q (PTR_W bits each, wrap naturally mod DEPTH), occupancy cnt_q (PTR_W+1 bits, 0..DEPTH).
- Push = in_valid_i & in_ready_o: entry[wr_q] ← payload, wr_q+1.
- Pop = cdb_valid_o & cdb_ready_i: rd_q+1.
- cnt_q next = cnt_q + push − pop; push and pop in same cycle leave cnt_q unchanged.
- in_ready_o = (cnt_q != DEPTH); depends only on registered state, never on cdb_ready_i or in_valid_i.
- cdb_valid_o = (cnt_q != 0); cdb_* payload = entry[rd_q] whenever valid; payload undefined-but-stable (not X-propagating, driven from array) when empty.
- No bypass: a result pushed into an empty buffer appears on cdb_* the following cycle.
- Full: push blocked even if pop occurs same cycle (ready is pre-pop). Empty: pop impossible; cdb_ready_i ignored.
- in_valid_i while in_ready_o=0: no state change; the producer must hold payload (its responsibility).
- rst or flush: wr_q=rd_q=0, cnt_q=0 next cycle; any same-cycle push/pop discarded. Array contents not reset.
- Ordering: strict FIFO; cdb_valid_o, once asserted for an entry, stays asserted with stable payload until popped or flushed.

## Timing
- Reset values: in_ready_o=1, cdb_valid_o=0, count_o=0; cdb_* payload don't-care.
- Latency in→cdb: 1 cycle minimum (push at edge N, visible after edge N).
- Throughput: 1 push and 1 pop per cycle sustained when 0<cnt_q<DEPTH.
- Free-slot reappearance: pop at edge N from full → in_ready_o=1 after edge N.
- Flush asserted in cycle N: cdb_valid_o=0 and in_ready_o=1 from cycle N+1; flush has priority over push/pop.
- All outputs registered-state-derived; no combinational path input→output.

## Structure
- Shared package (a_structure.svh): word_t, rob_id_t (existing); add alu_result_t struct {word_t data; rob_id_t rob_id; logic jump; word_t target;} for reuse by other execute-stage buffers and the CDB arbiter.
- One sub-module is natural: fifo_mem, a parameterised DEPTH×WIDTH synchronous-write, async-read register array (write enable/address, read address), reused by other queues. Control (pointers, count, handshakes) stays in alu_result_fifo.

## Test plan
- Reset: rst=1 two cycles → in_ready_o=1, cdb_valid_o=0, count_o=0; cdb_ready_i=1 with empty buffer → count stays 0.
- Fill/drain, DEPTH=4, cdb_ready_i=0: push data 0x11,0x22,0x33,0x44 with rob ids 1..4 → count_o=4, in_ready_o=0, fifth push (0x55) ignored; then cdb_ready_i=1 → outputs 0x11,0x22,0x33,0x44 on consecutive cycles, then cdb_valid_o=0.
- Simultaneous push/pop at count 2 for 10 cycles → count_o stays 2, outputs in push order, pointers wrap past 3 without loss.
- Full with pop: count 4, cdb_ready_i=1 and in_valid_i=1 same cycle → pop accepted, push rejected, count 3; next cycle push accepted, count 4.
- Flush mid-operation: count 3, assert flush with in_valid_i=1 and cdb_ready_i=1 → next cycle count_o=0, cdb_valid_o=0, in_ready_o=1; subsequent push 0xAA appears alone.
- Jump payload: push in_jump_i=1, in_target_i=0x1C000100, rob id 7 → cdb_jump_o=1, cdb_target_o=0x1C000100, cdb_rob_id_o=7 one cycle later, held stable under cdb_ready_i=0 for 5 cycles.
